// File: rtl/uart_tx_queue.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_queue
// Description : Circular byte FIFO feeding a UART transmitter, launching one
//               frame at a time via a start pulse and tracking busy/done.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_queue #(
    parameter int BITWIDTH  = 8,
    parameter int DEPTH     = 16,
    parameter int ADDRWIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 wrEn,
    input  logic [BITWIDTH-1:0]  wrData,
    output logic                 full,
    output logic                 empty,
    output logic [ADDRWIDTH:0]   count,
    output logic                 overflow,
    output logic                 TXstart,
    output logic [BITWIDTH-1:0]  TXdata,
    input  logic                 TXbusy,
    input  logic                 TXdone
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_START     = 2'd1,
        S_WAIT_ACK  = 2'd2,
        S_WAIT_DONE = 2'd3
    } state_t;

    localparam logic [ADDRWIDTH:0]   C_DEPTH   = (ADDRWIDTH+1)'(DEPTH);
    localparam logic [ADDRWIDTH:0]   C_CNT_ONE = (ADDRWIDTH+1)'(1);
    localparam logic [ADDRWIDTH-1:0] C_PTR_ONE = ADDRWIDTH'(1);

    logic [BITWIDTH-1:0]  mem_q [DEPTH];
    logic [ADDRWIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDRWIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDRWIDTH:0]   count_q,  count_d;
    logic                 overflow_q, overflow_d;
    state_t               state_q;
    logic                 txstart_q;
    logic [BITWIDTH-1:0]  txdata_q;

    logic w_full;
    logic w_empty;
    logic w_pop;
    logic w_push;
    logic w_drop;

    assign w_full  = (count_q == C_DEPTH);
    assign w_empty = (count_q == '0);

    // A pop frees a slot in the same cycle, so a write to a full queue still lands.
    assign w_pop  = (state_q == S_IDLE) && en && !w_empty && !TXbusy;
    assign w_push = wrEn && (!w_full || w_pop);
    assign w_drop = wrEn && w_full && !w_pop;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (w_push) begin
            wr_ptr_d = wr_ptr_q + C_PTR_ONE;
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + C_PTR_ONE;
        end
        if (w_push && !w_pop) begin
            count_d = count_q + C_CNT_ONE;
        end else if (w_pop && !w_push) begin
            count_d = count_q - C_CNT_ONE;
        end
        if (w_drop) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= wrData;
        end
    end

    // TXstart is registered alongside the IDLE->START transition so it is high
    // for exactly the cycle spent in START.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            txstart_q <= 1'b0;
            txdata_q  <= '0;
        end else begin
            txstart_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (w_pop) begin
                        state_q   <= S_START;
                        txstart_q <= 1'b1;
                        txdata_q  <= mem_q[rd_ptr_q];
                    end
                end
                S_START: begin
                    state_q <= S_WAIT_ACK;
                end
                S_WAIT_ACK: begin
                    if (TXdone) begin
                        state_q <= S_IDLE;
                    end else if (TXbusy) begin
                        state_q <= S_WAIT_DONE;
                    end
                end
                S_WAIT_DONE: begin
                    if (TXdone || !TXbusy) begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign full     = w_full;
    assign empty    = w_empty;
    assign count    = count_q;
    assign overflow = overflow_q;
    assign TXstart  = txstart_q;
    assign TXdata   = txdata_q;

endmodule
`default_nettype wire

// File: doc/uart_tx_queue.md
Name: uart_tx_queue

Overview:
- Transmit-side byte queue that sits directly upstream of the UART transmit stage.
- Host writes bytes into a circular FIFO. The block pops one byte at a time and presents it to transmit as a pulse on its start input plus its data input. It then sequences on transmit's busy/done outputs, so frames go out back-to-back with no host polling.
- Runs in the same clock domain as transmit (the TX clock from baudrategen). Host write port is synchronous to that clock.

Parameters:
- bitwidth, 8, data width per frame; must equal transmit's bitwidth.
- depth, 16, FIFO entries; power of two, minimum 2.
- addrwidth, 4, log2(depth); pointer width.

Ports:
- clk  input  1  clock; same clock that drives transmit.
- rst  input  1  synchronous active-high reset.
- en  input  1  1 = may launch new frames; 0 = hold queue (in-flight frame completes).
- wrEn  input  1  write strobe, one byte per cycle.
- wrData  input  bitwidth  byte to enqueue.
- full  output  1  count == depth.
- empty  output  1  count == 0.
- count  output  addrwidth+1  bytes currently queued (excludes byte in flight).
- overflow  output  1  sticky; set when a write is dropped; cleared only by rst.
- TXstart  output  1  one-cycle start pulse to transmit.
- TXdata  output  bitwidth  byte to transmit; stable from the TXstart cycle until the state returns to IDLE.
- TXbusy  input  1  transmit busy flag.
- TXdone  input  1  transmit frame-complete pulse.

Behaviour:
- Reset (synchronous, on clk edge with rst=1):
  - Pointers and count = 0; empty=1, full=0, overflow=0.
  - TXstart=0, TXdata=0, state=IDLE.
  - Applies mid-frame: queue flushed, the FSM abandons the in-flight frame, and TXstart does not pulse again until a new write.
- Storage:
  - depth x bitwidth array; wrPtr/rdPtr are addrwidth bits and wrap modulo depth.
  - count is updated registered: +1 on push only, -1 on pop only, unchanged on push+pop in the same cycle.
  - full/empty are derived from registered count.
- Push: wrEn=1 and (full=0 or pop in the same cycle).
- Write while full with no simultaneous pop: data dropped, count unchanged, overflow set to 1.
- Pop: occurs on the IDLE->START transition. Head byte is registered into TXdata at that edge; rdPtr advances.
- FSM states:
  - IDLE: when en=1, empty=0 and TXbusy=0, pop and go to START. Otherwise stay.
  - START: TXstart=1 for exactly this one cycle; next state WAIT_ACK.
  - WAIT_ACK: TXstart=0; stay until TXbusy=1, then go to WAIT_DONE. If TXdone=1 arrives here, go straight to IDLE (covers a transmit that skips busy).
  - WAIT_DONE: stay until TXdone=1 or TXbusy falls to 0, then go to IDLE.
- TXstart is a registered decode of state==START; no combinational path from wrEn to TXstart.
- Latency: a byte written at edge k into an empty queue, with en=1 and TXbusy=0, gives empty=0 after edge k, START after edge k+1, and TXstart=1 in the cycle between edges k+1 and k+2, with TXdata = that byte.
- Back-to-back: the next TXstart occurs no earlier than 2 cycles after the TXdone that completes the previous frame. At most one frame is in flight.
- en=0: IDLE does not pop; states past IDLE run to completion; writes are still accepted.
- Simultaneous push and pop when full: both succeed, count stays depth, overflow not set.
- Simultaneous push and pop when count=1: both succeed, count stays 1, empty stays 0.
- Pointer wrap: behaviour is identical across wrap; the byte order out equals the byte order in.

Test Plan:
- Reset: hold rst 2 cycles -> empty=1, full=0, count=0, overflow=0, TXstart=0, TXdata=0.
- Single byte: write 8'h55 with TXbusy=0 -> TXstart high exactly one cycle, 2 edges after the write, TXdata=8'h55. Model transmit asserting busy then TXdone -> state returns to IDLE, empty=1.
- Ordering and wrap, against a real transmit + receive chain:
  - With en=0, write 16 bytes 8'h00..8'h0F -> full=1, count=16; a 17th write 8'hAA is dropped and overflow=1.
  - Set en=1 -> receive outputs 8'h00..8'h0F in order.
  - Then write 8'h96, 8'h69 -> those bytes are received next (wrap path).
- Simultaneous push/pop: with count=16, write 8'h3C in the same cycle as a pop -> count stays 16, overflow unchanged, 8'h3C later emerges last.
- en gating: while a frame is in WAIT_DONE, drop en -> that frame completes with TXdone; no further TXstart while en=0 despite count=3; raising en resumes popping.
- Reset mid-frame: assert rst during WAIT_DONE with count=5 -> next cycle count=0, empty=1, TXstart=0; no TXstart afterwards without a new write.
